ysyx_22041211_lsu: RTL and testbench

- Multi-cycle load/store unit between the execute stage and the write-back stage.
- Accepts one instruction at a time from EXU (alu_result, store data, load/store type, rd info) over a valid/ready handshake.
- Performs the memory access over a simple request/response data bus, then aligns and extends load data.
- Presents wd/wreg/wdata to write-back over a valid/ready handshake; write-back consumes these directly and does no memory access itself.

---
 rtl/ysyx_22041211_lsu.sv | 197 +++++++++++++++++++
 tb/tb_ysyx_22041211_lsu.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041211_lsu.sv
// Multi-cycle load/store unit between EXU and WB: one instruction in flight, bus request/response.
// Optional macro YSYX_22041211_LSU_MISALIGN_EN traps misaligned half/word accesses without a bus cycle.
module ysyx_22041211_lsu #(
  parameter int unsigned DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic                wd_i,
  input  logic [4:0]          wreg_i,
  input  logic [DATA_LEN-1:0] alu_result_i,
  input  logic [DATA_LEN-1:0] store_data_i,
  input  logic [2:0]          load_type_i,
  input  logic [1:0]          store_type_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic                wd_o,
  output logic [4:0]          wreg_o,
  output logic [DATA_LEN-1:0] wdata_o,
  output logic                misalign_o,
  output logic                bus_req_valid_o,
  input  logic                bus_req_ready_i,
  output logic [DATA_LEN-1:0] bus_addr_o,
  output logic                bus_wen_o,
  output logic [DATA_LEN-1:0] bus_wdata_o,
  output logic [3:0]          bus_wstrb_o,
  input  logic                bus_resp_valid_i,
  input  logic [DATA_LEN-1:0] bus_rdata_i
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  localparam logic [2:0] LdLb  = 3'd1;
  localparam logic [2:0] LdLh  = 3'd2;
  localparam logic [2:0] LdLw  = 3'd3;
  localparam logic [2:0] LdLbu = 3'd4;
  localparam logic [2:0] LdLhu = 3'd5;
  localparam logic [1:0] StSb  = 2'd1;
  localparam logic [1:0] StSh  = 2'd2;
  localparam logic [1:0] StSw  = 2'd3;

  state_e              state_q;
  logic                rdy_q;
  logic                out_valid_q;
  logic                wd_q;
  logic [4:0]          wreg_q;
  logic [DATA_LEN-1:0] wdata_q;
  logic                misalign_q;
  logic [2:0]          ld_q;
  logic [1:0]          off_q;
  logic                req_valid_q;
  logic [DATA_LEN-1:0] bus_addr_q;
  logic                wen_q;
  logic [DATA_LEN-1:0] bus_wdata_q;
  logic [3:0]          wstrb_q;

  logic [1:0]          off;
  logic                is_load;
  logic                is_store;
  logic                mis;
  logic [DATA_LEN-1:0] lane_wdata;
  logic [3:0]          lane_strb;
  logic [DATA_LEN-1:0] rsh_b;
  logic [DATA_LEN-1:0] rsh_h;
  logic [DATA_LEN-1:0] ld_data;

  // A nonzero load type wins; a store type alongside it is ignored.
  always_comb begin
    off        = alu_result_i[1:0];
    is_load    = (load_type_i != 3'd0);
    is_store   = !is_load && (store_type_i != 2'd0);
    lane_wdata = store_data_i;
    lane_strb  = 4'b0000;
    if (is_store) begin
      unique case (store_type_i)
        StSb: begin
          lane_wdata = {4{store_data_i[7:0]}};
          lane_strb  = 4'b0001 << off;
        end
        StSh: begin
          lane_wdata = {2{store_data_i[15:0]}};
          lane_strb  = 4'b0011 << {off[1], 1'b0};
        end
        default: begin
          lane_wdata = store_data_i;
          lane_strb  = 4'b1111;
        end
      endcase
    end
  end

`ifdef YSYX_22041211_LSU_MISALIGN_EN
  always_comb begin
    mis = 1'b0;
    if (is_load && (load_type_i == LdLh || load_type_i == LdLhu) && off[0]) mis = 1'b1;
    if (is_load && load_type_i == LdLw && off != 2'b00) mis = 1'b1;
    if (is_store && store_type_i == StSh && off[0]) mis = 1'b1;
    if (is_store && store_type_i == StSw && off != 2'b00) mis = 1'b1;
  end
`else
  assign mis = 1'b0;
`endif

  always_comb begin
    rsh_b   = bus_rdata_i >> {off_q, 3'b000};
    rsh_h   = bus_rdata_i >> {off_q[1], 4'b0000};
    ld_data = bus_rdata_i;
    unique case (ld_q)
      LdLb:    ld_data = {{(DATA_LEN-8){rsh_b[7]}}, rsh_b[7:0]};
      LdLbu:   ld_data = {{(DATA_LEN-8){1'b0}}, rsh_b[7:0]};
      LdLh:    ld_data = {{(DATA_LEN-16){rsh_h[15]}}, rsh_h[15:0]};
      LdLhu:   ld_data = {{(DATA_LEN-16){1'b0}}, rsh_h[15:0]};
      LdLw:    ld_data = bus_rdata_i;
      default: ld_data = bus_rdata_i;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rdy_q       <= 1'b0;
      out_valid_q <= 1'b0;
      wd_q        <= 1'b0;
      wreg_q      <= '0;
      wdata_q     <= '0;
      misalign_q  <= 1'b0;
      ld_q        <= '0;
      off_q       <= '0;
      req_valid_q <= 1'b0;
      bus_addr_q  <= '0;
      wen_q       <= 1'b0;
      bus_wdata_q <= '0;
      wstrb_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          rdy_q <= 1'b1;
          if (rdy_q && in_valid_i) begin
            rdy_q      <= 1'b0;
            wd_q       <= mis ? 1'b0 : wd_i;
            wreg_q     <= wreg_i;
            wdata_q    <= alu_result_i;
            misalign_q <= mis;
            ld_q       <= load_type_i;
            off_q      <= off;
            if ((is_load || is_store) && !mis) begin
              req_valid_q <= 1'b1;
              bus_addr_q  <= {alu_result_i[DATA_LEN-1:2], 2'b00};
              wen_q       <= is_store;
              bus_wdata_q <= lane_wdata;
              wstrb_q     <= lane_strb;
              state_q     <= StReq;
            end else begin
              out_valid_q <= 1'b1;
              state_q     <= StDone;
            end
          end
        end
        StReq: begin
          if (bus_req_ready_i) begin
            req_valid_q <= 1'b0;
            state_q     <= StWait;
          end
        end
        StWait: begin
          if (bus_resp_valid_i) begin
            if (ld_q != 3'd0) wdata_q <= ld_data;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            rdy_q       <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready_o      = rdy_q;
  assign out_valid_o     = out_valid_q;
  assign wd_o            = wd_q;
  assign wreg_o          = wreg_q;
  assign wdata_o         = wdata_q;
  assign misalign_o      = misalign_q;
  assign bus_req_valid_o = req_valid_q;
  assign bus_addr_o      = bus_addr_q;
  assign bus_wen_o       = wen_q;
  assign bus_wdata_o     = bus_wdata_q;
  assign bus_wstrb_o     = wstrb_q;

endmodule

// File: tb/tb_ysyx_22041211_lsu.sv
// Directed bench for ysyx_22041211_lsu: ALU pass-through, loads, stalled store, WB backpressure,
// reset mid-transaction and misalignment handling.
module tb_ysyx_22041211_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid_i;
  logic        in_ready_o;
  logic        wd_i;
  logic [4:0]  wreg_i;
  logic [31:0] alu_result_i;
  logic [31:0] store_data_i;
  logic [2:0]  load_type_i;
  logic [1:0]  store_type_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic        wd_o;
  logic [4:0]  wreg_o;
  logic [31:0] wdata_o;
  logic        misalign_o;
  logic        bus_req_valid_o;
  logic        bus_req_ready_i;
  logic [31:0] bus_addr_o;
  logic        bus_wen_o;
  logic [31:0] bus_wdata_o;
  logic [3:0]  bus_wstrb_o;
  logic        bus_resp_valid_i;
  logic [31:0] bus_rdata_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_22041211_lsu #(.DATA_LEN(32)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid_i       (in_valid_i),
    .in_ready_o       (in_ready_o),
    .wd_i             (wd_i),
    .wreg_i           (wreg_i),
    .alu_result_i     (alu_result_i),
    .store_data_i     (store_data_i),
    .load_type_i      (load_type_i),
    .store_type_i     (store_type_i),
    .out_valid_o      (out_valid_o),
    .out_ready_i      (out_ready_i),
    .wd_o             (wd_o),
    .wreg_o           (wreg_o),
    .wdata_o          (wdata_o),
    .misalign_o       (misalign_o),
    .bus_req_valid_o  (bus_req_valid_o),
    .bus_req_ready_i  (bus_req_ready_i),
    .bus_addr_o       (bus_addr_o),
    .bus_wen_o        (bus_wen_o),
    .bus_wdata_o      (bus_wdata_o),
    .bus_wstrb_o      (bus_wstrb_o),
    .bus_resp_valid_i (bus_resp_valid_i),
    .bus_rdata_i      (bus_rdata_i)
  );

  // Presents one instruction for exactly one clock edge; caller is at posedge+1 with in_ready_o high.
  task automatic issue(input logic wd, input logic [4:0] wreg, input logic [31:0] alu,
                       input logic [31:0] sdata, input logic [2:0] lt, input logic [1:0] st);
    in_valid_i   = 1'b1;
    wd_i         = wd;
    wreg_i       = wreg;
    alu_result_i = alu;
    store_data_i = sdata;
    load_type_i  = lt;
    store_type_i = st;
    @(posedge clk); #1;
    in_valid_i   = 1'b0;
    load_type_i  = 3'd0;
    store_type_i = 2'd0;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({in_ready_o, out_valid_o, bus_req_valid_o, wd_o, wreg_o, wdata_o, misalign_o,
         bus_addr_o, bus_wen_o, bus_wdata_o, bus_wstrb_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b ov=%b rv=%b wdata=%h, required all zero",
               in_ready_o, out_valid_o, bus_req_valid_o, wdata_o);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({in_ready_o, out_valid_o} !== 2'b10) begin
      errors++;
      $display("FAIL reset_release: got rdy=%b ov=%b, required rdy=1 ov=0", in_ready_o, out_valid_o);
    end
  endtask

  task automatic test_alu;
    out_ready_i = 1'b1;
    issue(1'b1, 5'd5, 32'h0000_1234, 32'h0, 3'd0, 2'd0);
    checks++;
    if ({out_valid_o, wd_o, wreg_o, wdata_o, bus_req_valid_o, in_ready_o} !==
        {1'b1, 1'b1, 5'd5, 32'h0000_1234, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL alu_result: got ov=%b wd=%b wreg=%0d wdata=%h rv=%b, required 1 1 5 00001234 0",
               out_valid_o, wd_o, wreg_o, wdata_o, bus_req_valid_o);
    end
    @(posedge clk); #1;
    checks++;
    if ({out_valid_o, in_ready_o} !== 2'b01) begin
      errors++;
      $display("FAIL alu_retire: got ov=%b rdy=%b, required ov=0 rdy=1", out_valid_o, in_ready_o);
    end
  endtask

  task automatic test_load(input string name, input logic [2:0] lt, input logic [1:0] st,
                           input logic [31:0] addr, input logic [31:0] rdata,
                           input logic [31:0] exp_addr, input logic [31:0] exp_data);
    out_ready_i     = 1'b1;
    bus_req_ready_i = 1'b1;
    issue(1'b1, 5'd9, addr, 32'hCAFE_F00D, lt, st);
    checks++;
    if ({bus_req_valid_o, bus_addr_o, bus_wen_o, bus_wstrb_o, in_ready_o} !==
        {1'b1, exp_addr, 1'b0, 4'b0000, 1'b0}) begin
      errors++;
      $display("FAIL %s_req: got rv=%b addr=%h wen=%b strb=%b rdy=%b, required 1 %h 0 0000 0",
               name, bus_req_valid_o, bus_addr_o, bus_wen_o, bus_wstrb_o, in_ready_o, exp_addr);
    end
    @(posedge clk); #1;
    bus_resp_valid_i = 1'b1;
    bus_rdata_i      = rdata;
    @(posedge clk); #1;
    bus_resp_valid_i = 1'b0;
    checks++;
    if ({out_valid_o, wd_o, wreg_o, wdata_o, misalign_o} !==
        {1'b1, 1'b1, 5'd9, exp_data, 1'b0}) begin
      errors++;
      $display("FAIL %s_data: got ov=%b wd=%b wreg=%0d wdata=%h mis=%b, required 1 1 9 %h 0",
               name, out_valid_o, wd_o, wreg_o, wdata_o, misalign_o, exp_data);
    end
    @(posedge clk); #1;
    checks++;
    if ({out_valid_o, in_ready_o} !== 2'b01) begin
      errors++;
      $display("FAIL %s_retire: got ov=%b rdy=%b, required 0 1", name, out_valid_o, in_ready_o);
    end
  endtask

  task automatic test_store_stall;
    out_ready_i     = 1'b1;
    bus_req_ready_i = 1'b0;
    issue(1'b0, 5'd0, 32'h1000_0001, 32'h1234_56AB, 3'd0, 2'd1);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus_req_ready_i = 1'b1;
      checks++;
      if ({bus_req_valid_o, bus_addr_o, bus_wen_o, bus_wdata_o, bus_wstrb_o} !==
          {1'b1, 32'h1000_0000, 1'b1, 32'hABAB_ABAB, 4'b0010}) begin
        errors++;
        $display("FAIL sb_hold%0d: got rv=%b addr=%h wen=%b wdata=%h strb=%b, required 1 10000000 1 abababab 0010",
                 i, bus_req_valid_o, bus_addr_o, bus_wen_o, bus_wdata_o, bus_wstrb_o);
      end
      @(posedge clk); #1;
    end
    bus_req_ready_i = 1'b0;
    checks++;
    if ({bus_req_valid_o, out_valid_o} !== 2'b00) begin
      errors++;
      $display("FAIL sb_wait: got rv=%b ov=%b, required 0 0", bus_req_valid_o, out_valid_o);
    end
    bus_resp_valid_i = 1'b1;
    @(posedge clk); #1;
    bus_resp_valid_i = 1'b0;
    checks++;
    if ({out_valid_o, wd_o, wdata_o} !== {1'b1, 1'b0, 32'h1000_0001}) begin
      errors++;
      $display("FAIL sb_done: got ov=%b wd=%b wdata=%h, required 1 0 10000001",
               out_valid_o, wd_o, wdata_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    out_ready_i     = 1'b0;
    bus_req_ready_i = 1'b1;
    issue(1'b1, 5'd17, 32'h2000_0004, 32'h0, 3'd3, 2'd0);
    @(posedge clk); #1;
    bus_resp_valid_i = 1'b1;
    bus_rdata_i      = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      // Stray responses while holding the result must not disturb it.
      bus_resp_valid_i = 1'b1;
      bus_rdata_i      = 32'h5555_0000 + i;
      checks++;
      if ({out_valid_o, wd_o, wreg_o, wdata_o, in_ready_o} !==
          {1'b1, 1'b1, 5'd17, 32'hDEAD_BEEF, 1'b0}) begin
        errors++;
        $display("FAIL lw_hold%0d: got ov=%b wd=%b wreg=%0d wdata=%h rdy=%b, required 1 1 17 deadbeef 0",
                 i, out_valid_o, wd_o, wreg_o, wdata_o, in_ready_o);
      end
      @(posedge clk); #1;
    end
    bus_resp_valid_i = 1'b0;
    out_ready_i      = 1'b1;
    checks++;
    if ({out_valid_o, wdata_o} !== {1'b1, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL lw_last_hold: got ov=%b wdata=%h, required 1 deadbeef", out_valid_o, wdata_o);
    end
    @(posedge clk); #1;
    checks++;
    if ({out_valid_o, in_ready_o} !== 2'b01) begin
      errors++;
      $display("FAIL lw_accept: got ov=%b rdy=%b, required 0 1", out_valid_o, in_ready_o);
    end
  endtask

  task automatic test_reset_in_wait;
    out_ready_i     = 1'b1;
    bus_req_ready_i = 1'b1;
    issue(1'b1, 5'd3, 32'h3000_0008, 32'h0, 3'd3, 2'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready_o, out_valid_o, bus_req_valid_o, wd_o, wreg_o, wdata_o, bus_addr_o} !== '0) begin
      errors++;
      $display("FAIL rst_wait_clear: got rdy=%b ov=%b rv=%b wdata=%h addr=%h, required all zero",
               in_ready_o, out_valid_o, bus_req_valid_o, wdata_o, bus_addr_o);
    end
    @(posedge clk); #1;
    rst_n            = 1'b1;
    bus_resp_valid_i = 1'b1;
    bus_rdata_i      = 32'h7777_7777;
    @(posedge clk); #1;
    bus_resp_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({out_valid_o, bus_req_valid_o, wdata_o} !== {1'b0, 1'b0, 32'h0}) begin
        errors++;
        $display("FAIL rst_late_resp%0d: got ov=%b rv=%b wdata=%h, required 0 0 00000000",
                 i, out_valid_o, bus_req_valid_o, wdata_o);
      end
      @(posedge clk); #1;
    end
  endtask

`ifdef YSYX_22041211_LSU_MISALIGN_EN
  task automatic test_misalign;
    out_ready_i = 1'b1;
    issue(1'b1, 5'd4, 32'h0000_0002, 32'h0, 3'd3, 2'd0);
    checks++;
    if ({out_valid_o, misalign_o, wd_o, wdata_o, bus_req_valid_o} !==
        {1'b1, 1'b1, 1'b0, 32'h0000_0002, 1'b0}) begin
      errors++;
      $display("FAIL misalign_lw: got ov=%b mis=%b wd=%b wdata=%h rv=%b, required 1 1 0 00000002 0",
               out_valid_o, misalign_o, wd_o, wdata_o, bus_req_valid_o);
    end
    @(posedge clk); #1;
  endtask
`else
  task automatic test_misalign;
    test_load("lw_unaligned", 3'd3, 2'd0, 32'h0000_0002, 32'h1122_3344, 32'h0, 32'h1122_3344);
    test_load("lh_odd", 3'd2, 2'd0, 32'h8000_0001, 32'h1234_8765, 32'h8000_0000, 32'hFFFF_8765);
  endtask
`endif

  initial begin
    rst_n            = 1'b0;
    in_valid_i       = 1'b0;
    wd_i             = 1'b0;
    wreg_i           = '0;
    alu_result_i     = '0;
    store_data_i     = '0;
    load_type_i      = '0;
    store_type_i     = '0;
    out_ready_i      = 1'b1;
    bus_req_ready_i  = 1'b0;
    bus_resp_valid_i = 1'b0;
    bus_rdata_i      = '0;
    test_reset();
    test_alu();
    test_load("lb", 3'd1, 2'd0, 32'h8000_0003, 32'h80FF_FF7F, 32'h8000_0000, 32'hFFFF_FF80);
    test_load("lbu", 3'd4, 2'd0, 32'h8000_0003, 32'h80FF_FF7F, 32'h8000_0000, 32'h0000_0080);
    test_load("lh", 3'd2, 2'd0, 32'h8000_0002, 32'h8001_0000, 32'h8000_0000, 32'hFFFF_8001);
    test_load("lhu", 3'd5, 2'd0, 32'h8000_0002, 32'h8001_0000, 32'h8000_0000, 32'h0000_8001);
    test_load("ld_and_st", 3'd3, 2'd3, 32'h4000_0010, 32'h0BAD_F00D, 32'h4000_0010, 32'h0BAD_F00D);
    test_store_stall();
    test_backpressure();
    test_misalign();
    test_reset_in_wait();
    test_alu();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
